// File: rtl/rom_loader_defs.sv
// Shared constants for the UART boot loader: sync byte, FSM encodings and
// the bit-period derivation used by the receiver.
package rom_loader_defs;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_CNT_LO = 3'd1;
  localparam logic [2:0] ST_CNT_HI = 3'd2;
  localparam logic [2:0] ST_DATA   = 3'd3;
  localparam logic [2:0] ST_CHK    = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;
  localparam logic [2:0] ST_ERR    = 3'd6;

  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/rom_loader_rx.sv
// 8N1 UART byte receiver: 2-flop synchronizer, mid-bit sampling, glitch
// rejection on the start bit, one-cycle byte_valid / frame_err pulses.
module uart_rx_byte #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       uart_rx,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF = CNT_W'((CLKS_PER_BIT - 1) / 2);

  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  // [0],[1] synchronize; [2] holds the previous synced level for edge detect
  logic [2:0]       sync_q;
  logic [1:0]       rx_state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;
  logic             rx;

  assign rx = sync_q[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q     <= 3'b111;
      rx_state   <= RX_IDLE;
      cnt        <= '0;
      bit_idx    <= 3'd0;
      shift      <= 8'd0;
      byte_valid <= 1'b0;
      byte_data  <= 8'd0;
      frame_err  <= 1'b0;
    end else begin
      sync_q     <= {sync_q[1:0], uart_rx};
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (rx_state)
        // A true falling edge is required, so a line held low after a
        // framing error does not retrigger reception.
        RX_IDLE: begin
          if (sync_q[2] && !rx) begin
            rx_state <= RX_START;
            cnt      <= '0;
          end
        end
        RX_START: begin
          if (cnt == HALF) begin
            cnt      <= '0;
            bit_idx  <= 3'd0;
            rx_state <= rx ? RX_IDLE : RX_DATA;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        RX_DATA: begin
          if (cnt == FULL) begin
            cnt     <= '0;
            shift   <= {rx, shift[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) rx_state <= RX_STOP;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        RX_STOP: begin
          if (cnt == FULL) begin
            cnt      <= '0;
            rx_state <= RX_IDLE;
            if (rx) begin
              byte_valid <= 1'b1;
              byte_data  <= shift;
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/rom_loader.sv
// UART boot loader: writes a framed image into the instruction ROM and holds
// the core in reset until done. Optional checksum: ROM_LOADER_CHECKSUM_EN.
import rom_loader_defs::*;

module rom_loader #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 115200,
  parameter int ADDR_W   = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              uart_rx,
  output logic              rom_we,
  output logic [ADDR_W-1:0] rom_waddr,
  output logic [31:0]       rom_wdata,
  output logic              core_rst_n,
  output logic              load_done,
  output logic              load_err
);

  localparam int          CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
  localparam logic [16:0] MAX_WORDS    = 17'(1) << ADDR_W;

  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        frame_err;

  logic [2:0]  state;
  logic [1:0]  byte_cnt;
  logic [16:0] word_cnt;
  logic [15:0] n_words;
  logic [7:0]  cnt_lo;
  logic [23:0] word_sr;
  logic [15:0] n_rx;
`ifdef ROM_LOADER_CHECKSUM_EN
  logic [7:0]  chk_sum;
`endif

  uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk       (clk),
    .rst_n     (rst_n),
    .uart_rx   (uart_rx),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .frame_err (frame_err)
  );

  assign n_rx       = {byte_data, cnt_lo};
  assign load_done  = (state == ST_DONE);
  assign core_rst_n = (state == ST_DONE);
  assign load_err   = (state == ST_ERR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      byte_cnt  <= 2'd0;
      word_cnt  <= 17'd0;
      n_words   <= 16'd0;
      cnt_lo    <= 8'd0;
      word_sr   <= 24'd0;
      rom_we    <= 1'b0;
      rom_waddr <= '0;
      rom_wdata <= 32'd0;
`ifdef ROM_LOADER_CHECKSUM_EN
      chk_sum   <= 8'd0;
`endif
    end else begin
      rom_we <= 1'b0;
      if (rom_we) rom_waddr <= rom_waddr + 1'b1;

      if (frame_err && state != ST_IDLE && state != ST_DONE) begin
        state <= ST_ERR;
      end else begin
        case (state)
          ST_IDLE, ST_ERR: begin
            if (byte_valid && byte_data == SYNC_BYTE) begin
              state     <= ST_CNT_LO;
              byte_cnt  <= 2'd0;
              word_cnt  <= 17'd0;
              rom_waddr <= '0;
`ifdef ROM_LOADER_CHECKSUM_EN
              chk_sum   <= 8'd0;
`endif
            end
          end
          ST_CNT_LO: begin
            if (byte_valid) begin
              cnt_lo <= byte_data;
              state  <= ST_CNT_HI;
            end
          end
          ST_CNT_HI: begin
            if (byte_valid) begin
              n_words <= n_rx;
              if (n_rx == 16'd0 || {1'b0, n_rx} > MAX_WORDS) state <= ST_ERR;
              else state <= ST_DATA;
            end
          end
          ST_DATA: begin
            if (byte_valid) begin
              byte_cnt <= byte_cnt + 2'd1;
`ifdef ROM_LOADER_CHECKSUM_EN
              chk_sum  <= chk_sum + byte_data;
`endif
              if (byte_cnt == 2'd3) begin
                rom_we    <= 1'b1;
                rom_wdata <= {byte_data, word_sr};
                word_cnt  <= word_cnt + 17'd1;
              end else begin
                word_sr <= {byte_data, word_sr[23:8]};
              end
            end else if (rom_we && word_cnt == {1'b0, n_words}) begin
              // Leave only once the final strobe is on the port, so the core
              // release always trails the last write.
`ifdef ROM_LOADER_CHECKSUM_EN
              state <= ST_CHK;
`else
              state <= ST_DONE;
`endif
            end
          end
`ifdef ROM_LOADER_CHECKSUM_EN
          ST_CHK: begin
            if (byte_valid) state <= (byte_data == chk_sum) ? ST_DONE : ST_ERR;
          end
`endif
          ST_DONE: state <= ST_DONE;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rom_loader.sv
// Directed bench for rom_loader: header table plus multi-cycle sequences for
// framing errors, recovery, checksum and mid-load reset.
module tb_rom_loader;

  localparam int CPB = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        uart_rx = 1'b1;
  logic        rom_we;
  logic [3:0]  rom_waddr;
  logic [31:0] rom_wdata;
  logic        core_rst_n, load_done, load_err;

  always #5 clk = ~clk;

  rom_loader #(.CLK_FREQ(160), .BAUD(10), .ADDR_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .uart_rx   (uart_rx),
    .rom_we    (rom_we),
    .rom_waddr (rom_waddr),
    .rom_wdata (rom_wdata),
    .core_rst_n(core_rst_n),
    .load_done (load_done),
    .load_err  (load_err)
  );

  int total = 0;
  int bad   = 0;

  logic        clr_log = 1'b0;
  int          wr_cnt;
  logic [3:0]  wr_addr [0:15];
  logic [31:0] wr_data [0:15];
  logic        we_prev, core_prev;
  int          b2b, cyc, last_we_cyc;
  int          min_lag = 1000;

  always @(posedge clk) begin
    cyc       <= cyc + 1;
    we_prev   <= rom_we;
    core_prev <= core_rst_n;
    if (rom_we && we_prev) b2b <= b2b + 1;
    if (core_rst_n && !core_prev && (cyc - last_we_cyc) < min_lag) min_lag <= cyc - last_we_cyc;
    if (rom_we) last_we_cyc <= cyc;
    if (clr_log) wr_cnt <= 0;
    else if (rom_we) begin
      if (wr_cnt < 16) begin
        wr_addr[wr_cnt[3:0]] <= rom_waddr;
        wr_data[wr_cnt[3:0]] <= rom_wdata;
      end
      wr_cnt <= wr_cnt + 1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    @(negedge clk);
    uart_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    uart_rx = stop;
    repeat (CPB) @(negedge clk);
    uart_rx = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] w);
    send_byte(w[7:0], 1'b1);
    send_byte(w[15:8], 1'b1);
    send_byte(w[23:16], 1'b1);
    send_byte(w[31:24], 1'b1);
  endtask

  function automatic logic [7:0] wsum(input logic [31:0] w);
    return w[7:0] + w[15:8] + w[23:16] + w[31:24];
  endfunction

  task automatic send_image(input int n, input logic [31:0] w0, input logic [31:0] w1,
                            input logic corrupt);
    logic [7:0] s;
    send_byte(8'hA5, 1'b1);
    send_byte(8'(n), 1'b1);
    send_byte(8'h00, 1'b1);
    send_word(w0);
    s = wsum(w0);
    if (n > 1) begin
      send_word(w1);
      s = s + wsum(w1);
    end
`ifdef ROM_LOADER_CHECKSUM_EN
    send_byte(corrupt ? s + 8'd1 : s, 1'b1);
`else
    if (corrupt && s == 8'd0) repeat (1) @(negedge clk);
`endif
    repeat (4) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    clr_log = 1'b1;
    repeat (3) @(negedge clk);
    rst_n   = 1'b1;
    clr_log = 1'b0;
    @(negedge clk);
  endtask

  typedef struct {
    logic [7:0]  lo;
    logic [7:0]  hi;
    logic [31:0] w;
    logic        exp_err;
    int          exp_wr;
  } hdr_vec_t;

  hdr_vec_t tv [0:4];

  initial begin
    tv[0] = '{8'h00, 8'h00, 32'h0,         1'b1, 0};  // N = 0
    tv[1] = '{8'h11, 8'h00, 32'h0,         1'b1, 0};  // N = 17 > 16
    tv[2] = '{8'h00, 8'h01, 32'h0,         1'b1, 0};  // N = 256
    tv[3] = '{8'h01, 8'h00, 32'hA5A5_00A5, 1'b0, 1};  // sync value inside data
    tv[4] = '{8'h01, 8'h00, 32'hFFFF_FFFF, 1'b0, 1};

    // reset state
    repeat (2) @(negedge clk);
    clr_log = 1'b1;
    chk("rst_we",    {31'd0, rom_we},     32'd0);
    chk("rst_waddr", {28'd0, rom_waddr},  32'd0);
    chk("rst_wdata", rom_wdata,           32'd0);
    chk("rst_core",  {31'd0, core_rst_n}, 32'd0);
    chk("rst_done",  {31'd0, load_done},  32'd0);
    chk("rst_err",   {31'd0, load_err},   32'd0);
    do_reset();

    // header table
    for (int k = 0; k < 5; k++) begin
      do_reset();
      send_byte(8'hA5, 1'b1);
      send_byte(tv[k].lo, 1'b1);
      send_byte(tv[k].hi, 1'b1);
      if (!tv[k].exp_err) begin
        send_word(tv[k].w);
`ifdef ROM_LOADER_CHECKSUM_EN
        send_byte(wsum(tv[k].w), 1'b1);
`endif
      end
      repeat (4) @(negedge clk);
      chk($sformatf("tv%0d_err", k),  {31'd0, load_err},   {31'd0, tv[k].exp_err});
      chk($sformatf("tv%0d_done", k), {31'd0, load_done},  {31'd0, !tv[k].exp_err});
      chk($sformatf("tv%0d_core", k), {31'd0, core_rst_n}, {31'd0, !tv[k].exp_err});
      chk($sformatf("tv%0d_wr", k),   32'(wr_cnt),         32'(tv[k].exp_wr));
      if (tv[k].exp_wr == 1) begin
        chk($sformatf("tv%0d_d0", k), wr_data[0],           tv[k].w);
        chk($sformatf("tv%0d_a0", k), {28'd0, wr_addr[0]},  32'd0);
      end
    end

    // two-word image, then bytes after DONE are ignored
    do_reset();
    send_image(2, 32'h0000_0013, 32'h0000_02B7, 1'b0);
    chk("img_wr",   32'(wr_cnt),         32'd2);
    chk("img_a0",   {28'd0, wr_addr[0]}, 32'd0);
    chk("img_d0",   wr_data[0],          32'h0000_0013);
    chk("img_a1",   {28'd0, wr_addr[1]}, 32'd1);
    chk("img_d1",   wr_data[1],          32'h0000_02B7);
    chk("img_done", {31'd0, load_done},  32'd1);
    chk("img_core", {31'd0, core_rst_n}, 32'd1);
    chk("img_err",  {31'd0, load_err},   32'd0);
    send_image(1, 32'h1111_2222, 32'h0, 1'b0);
    chk("done_abs_wr",   32'(wr_cnt),        32'd2);
    chk("done_abs_done", {31'd0, load_done}, 32'd1);

    // leading junk
    do_reset();
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    send_byte(8'h5A, 1'b1);
    chk("junk_nowr", 32'(wr_cnt), 32'd0);
    send_image(1, 32'hDEAD_BEEF, 32'h0, 1'b0);
    chk("junk_wr",   32'(wr_cnt),        32'd1);
    chk("junk_d0",   wr_data[0],         32'hDEAD_BEEF);
    chk("junk_a0",   {28'd0, wr_addr[0]}, 32'd0);
    chk("junk_done", {31'd0, load_done}, 32'd1);

    // N = 0 then recovery without reset
    do_reset();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    repeat (4) @(negedge clk);
    chk("n0_err",  {31'd0, load_err},   32'd1);
    chk("n0_core", {31'd0, core_rst_n}, 32'd0);
    chk("n0_wr",   32'(wr_cnt),         32'd0);
    send_image(1, 32'h1234_5678, 32'h0, 1'b0);
    chk("rec_err",  {31'd0, load_err},  32'd0);
    chk("rec_done", {31'd0, load_done}, 32'd1);
    chk("rec_wr",   32'(wr_cnt),        32'd1);
    chk("rec_d0",   wr_data[0],         32'h1234_5678);

    // framing error on the 3rd data byte
    do_reset();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h13, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b0);
    repeat (2 * CPB) @(negedge clk);
    chk("fe_err",  {31'd0, load_err},   32'd1);
    chk("fe_core", {31'd0, core_rst_n}, 32'd0);
    chk("fe_wr",   32'(wr_cnt),         32'd0);

`ifdef ROM_LOADER_CHECKSUM_EN
    // bad checksum, then the correct image
    do_reset();
    send_image(2, 32'h0000_0013, 32'h0000_02B7, 1'b1);
    chk("cs_wr",   32'(wr_cnt),         32'd2);
    chk("cs_err",  {31'd0, load_err},   32'd1);
    chk("cs_core", {31'd0, core_rst_n}, 32'd0);
    send_image(2, 32'h0000_0013, 32'h0000_02B7, 1'b0);
    chk("cs2_wr",   32'(wr_cnt),         32'd4);
    chk("cs2_a2",   {28'd0, wr_addr[2]}, 32'd0);
    chk("cs2_done", {31'd0, load_done},  32'd1);
    chk("cs2_err",  {31'd0, load_err},   32'd0);
`endif

    // reset after 5 of 8 data bytes
    do_reset();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h00, 1'b1);
    send_word(32'h4433_2211);
    send_byte(8'h55, 1'b1);
    chk("mid_wr",    32'(wr_cnt),        32'd1);
    chk("mid_waddr", {28'd0, rom_waddr}, 32'd1);
    #3 rst_n = 1'b0;
    #1;
    chk("mr_waddr", {28'd0, rom_waddr},  32'd0);
    chk("mr_wdata", rom_wdata,           32'd0);
    chk("mr_we",    {31'd0, rom_we},     32'd0);
    chk("mr_core",  {31'd0, core_rst_n}, 32'd0);
    chk("mr_done",  {31'd0, load_done},  32'd0);
    chk("mr_err",   {31'd0, load_err},   32'd0);
    do_reset();
    send_image(1, 32'hCAFE_F00D, 32'h0, 1'b0);
    chk("mr2_wr",   32'(wr_cnt),         32'd1);
    chk("mr2_a0",   {28'd0, wr_addr[0]}, 32'd0);
    chk("mr2_d0",   wr_data[0],          32'hCAFE_F00D);
    chk("mr2_done", {31'd0, load_done},  32'd1);

    chk("no_b2b",      32'(b2b),             32'd0);
    chk("release_lag", {31'd0, min_lag >= 1}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
